d_latch_checker: RTL

//  Synthesizable stimulus/response partner for the d_latch interface (D, En -> Q, Qbar).

---
 rtl/d_latch_chk_if.sv | 21 ++
 rtl/d_latch_checker.sv | 103 ++++++++++
 2 files changed

// File: rtl/d_latch_chk_if.sv
// d_latch_chk_if: run-control and latch drive/response bundle for d_latch_checker; master is the checker.
interface d_latch_chk_if;
  logic       START;
  logic       D;
  logic       En;
  logic       Q;
  logic       Qbar;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [3:0] ERR_COUNT;
  logic [2:0] ERR_IDX;
  modport master (
    input  START, Q, Qbar,
    output D, En, BUSY, DONE, PASS, ERR_COUNT, ERR_IDX
  );
  modport slave (
    output START, Q, Qbar,
    input  D, En, BUSY, DONE, PASS, ERR_COUNT, ERR_IDX
  );
endinterface

// File: rtl/d_latch_checker.sv
// d_latch_checker: drives an 8-entry {D,En} pattern into a d_latch and checks Q/Qbar against a latch model.
// Define D_LATCH_CHK_HALT_EN to stop the run at the first mismatch.
module d_latch_checker #(
  parameter logic [15:0] PATTERN       = 16'h2C98,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic           CLK,
  input logic           RST,
  d_latch_chk_if.master bus
);
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, FIN} state_t;
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be 1..15");
  end
  state_t     state_q;
  logic [2:0] idx_q;
  logic [3:0] cnt_q;
  logic       model_q;
  logic       model_valid_q;
  logic       d_q;
  logic       en_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] err_cnt_q;
  logic [2:0] err_idx_q;
  logic [1:0] ent_d;
  logic       mism_d;
  logic       go_d;
  logic [3:0] err_cnt_d;
  assign ent_d     = PATTERN[2*idx_q +: 2];
  assign mism_d    = model_valid_q && (bus.Q != model_q || bus.Qbar != ~model_q);
  assign go_d      = bus.START && (state_q == IDLE || state_q == FIN);
  assign err_cnt_d = (err_cnt_q == 4'hF) ? 4'hF : err_cnt_q + 4'd1;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      model_q       <= 1'b0;
      model_valid_q <= 1'b0;
      d_q           <= 1'b0;
      en_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_cnt_q     <= '0;
      err_idx_q     <= '0;
    end else if (go_d) begin
      state_q       <= DRIVE;
      idx_q         <= '0;
      model_q       <= 1'b0;
      model_valid_q <= 1'b0;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_cnt_q     <= '0;
      err_idx_q     <= '0;
    end else begin
      case (state_q)
        DRIVE: begin
          d_q     <= ent_d[1];
          en_q    <= ent_d[0];
          cnt_q   <= '0;
          state_q <= SETTLE;
          if (ent_d[0]) begin
            model_q       <= ent_d[1];
            model_valid_q <= 1'b1;
          end
        end
        SETTLE: begin
          cnt_q   <= cnt_q + 4'd1;
          state_q <= (cnt_q == 4'(SETTLE_CYCLES - 1)) ? CHECK : SETTLE;
        end
        CHECK: begin
          if (mism_d) begin
            err_cnt_q <= err_cnt_d;
            if (err_cnt_q == '0) err_idx_q <= idx_q;
          end
`ifdef D_LATCH_CHK_HALT_EN
          state_q <= (mism_d || idx_q == 3'd7) ? FIN : DRIVE;
`else
          state_q <= (idx_q == 3'd7) ? FIN : DRIVE;
`endif
          idx_q   <= idx_q + 3'd1;
        end
        FIN: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          pass_q <= (err_cnt_q == '0);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.D         = d_q;
  assign bus.En        = en_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.PASS      = pass_q;
  assign bus.ERR_COUNT = err_cnt_q;
  assign bus.ERR_IDX   = err_idx_q;
endmodule
